mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 94 +++++++++
 rtl/mc_controller_if.sv | 51 +++++
 rtl/mc_branch_cond.sv | 24 ++
 rtl/mc_controller.sv | 153 +++++++++++++++
 tb/tb_mc_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared RISC-V opcode, state and ALU-op definitions
// for the multi-cycle controller and its branch-condition helper.
package mc_controller_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_LS    = 2'b00,
        ALU_BR    = 2'b01,
        ALU_R     = 2'b10,
        ALU_OTHER = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        IC_R,
        IC_I,
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_LUI,
        IC_AUIPC,
        IC_JAL,
        IC_JALR,
        IC_UNKNOWN
    } inst_class_e;

    typedef struct packed {
        logic    jump;
        logic    jalr;
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_to_reg;
    } dec_t;

    function automatic inst_class_e classify(input logic [6:0] opc);
        inst_class_e c;
        case (opc)
            OPC_R:      c = IC_R;
            OPC_I:      c = IC_I;
            OPC_LOAD:   c = IC_LOAD;
            OPC_STORE:  c = IC_STORE;
            OPC_BRANCH: c = IC_BRANCH;
            OPC_LUI:    c = IC_LUI;
            OPC_AUIPC:  c = IC_AUIPC;
            OPC_JAL:    c = IC_JAL;
            OPC_JALR:   c = IC_JALR;
            default:    c = IC_UNKNOWN;
        endcase
        return c;
    endfunction

    function automatic dec_t decode(input inst_class_e c);
        dec_t d;
        d.jump       = (c == IC_JAL);
        d.jalr       = (c == IC_JALR);
        d.mem_to_reg = (c == IC_LOAD);
        d.alu_src    = c inside {IC_I, IC_LOAD, IC_STORE, IC_LUI,
                                 IC_AUIPC, IC_JAL, IC_JALR};
        case (c)
            IC_R:              d.alu_op = ALU_R;
            IC_BRANCH:         d.alu_op = ALU_BR;
            IC_LOAD, IC_STORE: d.alu_op = ALU_LS;
            default:           d.alu_op = ALU_OTHER;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction/ALU/memory handshake bundle of the controller.
// Macro MC_CONTROLLER_TRAP_EN adds the illegal_inst indication.
interface mc_controller_if;

    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] alu_result;
    logic        zero;
    logic        mem_ready;

    logic        ir_write;
    logic        pc_write;
    logic        branch_taken;
    logic        jump;
    logic        jalr;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        io_read;
    logic        io_write;
    logic        reg_write;
    logic [2:0]  state;
`ifdef MC_CONTROLLER_TRAP_EN
    logic        illegal_inst;
`endif

    modport master (
        input  inst, inst_valid, alu_result, zero, mem_ready,
        output ir_write, pc_write, branch_taken, jump, jalr,
        output alu_op, alu_src, mem_to_reg,
        output mem_read, mem_write, io_read, io_write, reg_write,
        output state
`ifdef MC_CONTROLLER_TRAP_EN
        , output illegal_inst
`endif
    );

    modport slave (
        output inst, inst_valid, alu_result, zero, mem_ready,
        input  ir_write, pc_write, branch_taken, jump, jalr,
        input  alu_op, alu_src, mem_to_reg,
        input  mem_read, mem_write, io_read, io_write, reg_write,
        input  state
`ifdef MC_CONTROLLER_TRAP_EN
        , input illegal_inst
`endif
    );

endinterface

// File: rtl/mc_branch_cond.sv
// mc_branch_cond: evaluates the branch outcome from funct3, the ALU zero flag
// and the SLT/SLTU result bit computed by the ALU.
module mc_branch_cond
    import mc_controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken
);

    // Select the comparison that matches the branch flavour
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = !zero;
            F3_BLT, F3_BLTU:  taken = lt;
            F3_BGE, F3_BGEU:  taken = !lt;
            default:          taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define MC_CONTROLLER_TRAP_EN to trap on unknown opcodes instead of NOP-ing them.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int                 IO_LSB  = 8,
    parameter logic [31-IO_LSB:0] IO_BASE = 24'hFFFFFC
) (
    input logic             clk,
    input logic             rst,
    mc_controller_if.master bus
);

    state_e      r_state;
    state_e      w_next;
    logic [31:0] r_ir;
    logic [31:0] r_addr_q;
    inst_class_e w_cls;
    dec_t        w_dec;
    logic        w_is_io;
    logic        w_taken;
    logic        w_unused;

    assign w_cls   = classify(r_ir[6:0]);
    assign w_dec   = decode(w_cls);
    assign w_is_io = (r_addr_q[31:IO_LSB] == IO_BASE);

    // Only opcode/funct3 of IR and the page bits of the address matter here
    assign w_unused = ^{r_ir[31:15], r_ir[11:7], r_addr_q[IO_LSB-1:0]};

    mc_branch_cond u_branch_cond (
        .funct3 (r_ir[14:12]),
        .zero   (bus.zero),
        .lt     (bus.alu_result[0]),
        .taken  (w_taken)
    );

    assign bus.jump       = w_dec.jump;
    assign bus.jalr       = w_dec.jalr;
    assign bus.alu_op     = w_dec.alu_op;
    assign bus.alu_src    = w_dec.alu_src;
    assign bus.mem_to_reg = w_dec.mem_to_reg;
    assign bus.state      = r_state;
`ifdef MC_CONTROLLER_TRAP_EN
    assign bus.illegal_inst = (r_state == ST_TRAP);
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction register, loaded on the FETCH handshake only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir <= INST_NOP;
        end else if (r_state == ST_FETCH && bus.inst_valid) begin
            r_ir <= bus.inst;
        end
    end

    // Effective address captured in EXEC for the MEM-stage IO decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q <= '0;
        end else if (r_state == ST_EXEC) begin
            r_addr_q <= bus.alu_result;
        end
    end

    // Next-state selection and per-state strobes
    always_comb begin
        w_next           = r_state;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.io_read      = 1'b0;
        bus.io_write     = 1'b0;
        bus.reg_write    = 1'b0;
        unique case (r_state)
            ST_FETCH: begin
                if (bus.inst_valid) begin
                    bus.ir_write = 1'b1;
                    w_next       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (w_cls)
                    IC_LOAD, IC_STORE: begin
                        w_next = ST_MEM;
                    end
                    IC_BRANCH: begin
                        bus.pc_write     = 1'b1;
                        bus.branch_taken = w_taken;
                        w_next           = ST_FETCH;
                    end
                    IC_R, IC_I, IC_LUI, IC_AUIPC, IC_JAL, IC_JALR: begin
                        w_next = ST_WB;
                    end
                    default: begin
`ifdef MC_CONTROLLER_TRAP_EN
                        w_next = ST_TRAP;
`else
                        bus.pc_write = 1'b1;
                        w_next       = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                if (w_cls == IC_LOAD) begin
                    bus.io_read  = w_is_io;
                    bus.mem_read = !w_is_io;
                    if (bus.mem_ready) begin
                        w_next = ST_WB;
                    end
                end else begin
                    bus.io_write  = w_is_io;
                    bus.mem_write = !w_is_io;
                    if (bus.mem_ready) begin
                        bus.pc_write = 1'b1;
                        w_next       = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                bus.reg_write = 1'b1;
                bus.pc_write  = 1'b1;
                w_next        = ST_FETCH;
            end
            ST_TRAP: begin
`ifdef MC_CONTROLLER_TRAP_EN
                w_next = ST_TRAP;
`else
                w_next = ST_FETCH;
`endif
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed and random instruction streams for mc_controller,
// checked cycle by cycle against a latency/strobe schedule model.
module tb_mc_controller;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    logic [31:0] ir_m;
    logic [6:0]  opcs [10];

    always #5 clk = ~clk;

    mc_controller_if bus ();

    mc_controller #(
        .IO_LSB  (8),
        .IO_BASE (24'hFFFFFC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [4:0] dec_exp(input logic [31:0] ir);
        logic [6:0] op;
        logic [1:0] aop;
        logic       src;
        op = ir[6:0];
        case (op)
            7'h33:        aop = 2'b10;
            7'h63:        aop = 2'b01;
            7'h03, 7'h23: aop = 2'b00;
            default:      aop = 2'b11;
        endcase
        src = op inside {7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};
        return {op == 7'h6F, op == 7'h67, aop, src, op == 7'h03};
    endfunction

    function automatic logic taken_exp(input logic [2:0] f3, input logic z,
                                       input logic [31:0] r);
        logic t;
        case (f3)
            3'd0:       t = z;
            3'd1:       t = !z;
            3'd4, 3'd6: t = r[0];
            3'd5, 3'd7: t = !r[0];
            default:    t = 1'b0;
        endcase
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag, input logic [2:0] st,
                          input logic [7:0] sb, input logic [31:0] ir);
        logic [7:0] obs_sb;
        logic [4:0] obs_dec;
        obs_sb  = {bus.ir_write, bus.pc_write, bus.branch_taken, bus.mem_read,
                   bus.mem_write, bus.io_read, bus.io_write, bus.reg_write};
        obs_dec = {bus.jump, bus.jalr, bus.alu_op, bus.alu_src, bus.mem_to_reg};
        check({tag, ":state"}, 32'(bus.state), 32'(st));
        check({tag, ":strobes"}, 32'(obs_sb), 32'(sb));
        check({tag, ":decode"}, 32'(obs_dec), 32'(dec_exp(ir)));
`ifdef MC_CONTROLLER_TRAP_EN
        check({tag, ":illegal"}, 32'(bus.illegal_inst), 32'(st == 3'd5));
`endif
    endtask

    task automatic drive_noise();
        bus.inst       = $urandom;
        bus.alu_result = $urandom;
        bus.zero       = 1'($urandom_range(0, 1));
        bus.mem_ready  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive_noise();
            bus.inst_valid = 1'b0;
            rst = 1'b0;
            #1 sample("idle", 3'd0, 8'h00, ir_m);
        end
    endtask

    task automatic run_inst(input string tag, input logic [31:0] instr,
                            input int stalls, input logic [31:0] ex_res,
                            input logic ex_zero, input int rst_at);
        logic [6:0] op;
        logic       is_ld, is_st, is_br, is_wb, is_unk, io, tk, trap_en;
        int         ncyc;
        op     = instr[6:0];
        is_ld  = (op == 7'h03);
        is_st  = (op == 7'h23);
        is_br  = (op == 7'h63);
        is_wb  = op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
        is_unk = !(is_ld || is_st || is_br || is_wb);
        io     = (ex_res[31:8] == 24'hFFFFFC);
        tk     = taken_exp(instr[14:12], ex_zero, ex_res);
`ifdef MC_CONTROLLER_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        if (is_ld)      ncyc = 5 + stalls;
        else if (is_st) ncyc = 4 + stalls;
        else if (is_wb) ncyc = 4;
        else            ncyc = 3;
        for (int k = 0; k < ncyc; k++) begin
            logic [2:0] st;
            logic [7:0] sb;
            logic       in_mem;
            @(negedge clk);
            drive_noise();
            in_mem = (is_ld || is_st) && k >= 3 && k <= 3 + stalls;
            bus.inst_valid = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (k == 0) bus.inst = instr;
            if (k == 2) begin
                bus.alu_result = ex_res;
                bus.zero       = ex_zero;
            end
            if (in_mem) bus.mem_ready = (k == 3 + stalls);
            rst = (k == rst_at);
            if (k < 3)       st = 3'(k);
            else if (in_mem) st = 3'd3;
            else             st = 3'd4;
            sb = 8'h00;
            if (k == 0) sb[7] = 1'b1;
            if (k == 2 && is_br) begin
                sb[6] = 1'b1;
                sb[5] = tk;
            end
            if (k == 2 && is_unk && !trap_en) sb[6] = 1'b1;
            if (in_mem && is_ld) begin
                sb[4] = !io;
                sb[2] = io;
            end
            if (in_mem && is_st) begin
                sb[3] = !io;
                sb[1] = io;
                if (k == 3 + stalls) sb[6] = 1'b1;
            end
            if ((is_wb && k == 3) || (is_ld && k == 4 + stalls)) begin
                sb[6] = 1'b1;
                sb[0] = 1'b1;
            end
            #1 sample(tag, st, sb, (k == 0) ? ir_m : instr);
            if (k == rst_at) break;
        end
        if (rst_at >= 0) begin
            @(negedge clk);
            drive_noise();
            bus.inst_valid = 1'b0;
            rst = 1'b0;
            ir_m = NOP;
            #1 sample({tag, ":post_rst"}, 3'd0, 8'h00, NOP);
        end else begin
            ir_m = instr;
        end
    endtask

    initial begin
        logic [31:0] instr;
        logic [31:0] res;
        int          hi;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        rst            = 1'b1;
        bus.inst       = '0;
        bus.inst_valid = 1'b0;
        bus.alu_result = '0;
        bus.zero       = 1'b0;
        bus.mem_ready  = 1'b0;
        ir_m           = NOP;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 sample("reset", 3'd0, 8'h00, NOP);
        idle(2);

        run_inst("addi", 32'h00500093, 0, 32'h5, 1'b0, -1);
        idle(1);
        run_inst("lw_io", 32'h0000A103, 2, 32'hFFFFFC10, 1'b0, -1);
        run_inst("sw_mem", 32'h0020A023, 0, 32'h00000040, 1'b0, -1);
        idle(1);
        run_inst("bne", 32'h00209063, 0, 32'h7, 1'b0, -1);
        run_inst("beq", 32'h00208063, 0, 32'h7, 1'b0, -1);
        run_inst("blt", 32'h0020C063, 0, 32'h1, 1'b0, -1);
        run_inst("lw_rst", 32'h0000A103, 3, 32'h00000100, 1'b0, 4);
        idle(1);

        for (int n = 0; n < 60; n++) begin
`ifdef MC_CONTROLLER_TRAP_EN
            hi = 8;
`else
            hi = 9;
`endif
            instr = $urandom;
            instr[6:0] = opcs[$urandom_range(0, hi)];
            if ($urandom_range(0, 1) == 1) res = {24'hFFFFFC, 8'($urandom)};
            else                          res = $urandom & 32'h00FFFFFF;
            run_inst("rand", instr, $urandom_range(0, 3), res,
                     1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
        end

`ifdef MC_CONTROLLER_TRAP_EN
        run_inst("trap", 32'h0000007F, 0, 32'h0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_noise();
            bus.inst_valid = 1'b1;
            bus.mem_ready  = 1'b1;
            #1 sample("trap_hold", 3'd5, 8'h00, ir_m);
        end
        @(negedge clk);
        bus.inst_valid = 1'b0;
        rst = 1'b1;
        #1 sample("trap_rst", 3'd5, 8'h00, ir_m);
        @(negedge clk);
        rst = 1'b0;
        ir_m = NOP;
        #1 sample("trap_clr", 3'd0, 8'h00, NOP);
`else
        run_inst("op7f", 32'h0000007F, 0, 32'h0, 1'b0, -1);
        idle(1);
`endif
        run_inst("addi_end", 32'h00500093, 0, 32'h5, 1'b0, -1);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
